// File: rtl/pe_fi_pkg.sv
// Shared types and the fault-application helper for the weight-stationary PE.
// Fault values are processed at FI_MAX_W bits and truncated by the caller.
package pe_fi_pkg;

    localparam int FI_MAX_W = 64;

    typedef enum logic [1:0] {
        TGT_STAT   = 2'd0,
        TGT_STREAM = 2'd1,
        TGT_PSUM   = 2'd2,
        TGT_NONE   = 2'd3
    } fi_target_e;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_FLIP = 2'd1,
        MODE_SA0  = 2'd2,
        MODE_SA1  = 2'd3
    } fi_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } fi_state_e;

    function automatic logic [FI_MAX_W-1:0] apply_fault(
        input logic [FI_MAX_W-1:0] val,
        input logic [FI_MAX_W-1:0] mask,
        input fi_mode_e            mode
    );
        case (mode)
            MODE_FLIP: return val ^ mask;
            MODE_SA0:  return val & ~mask;
            MODE_SA1:  return val | mask;
            default:   return val;
        endcase
    endfunction

endpackage

// File: rtl/pe_fi_sequencer.sv
// Fault-window sequencer: holds the latched fault configuration and walks
// IDLE -> ARMED -> ACTIVE -> DONE, producing fi_active and fi_done.
module pe_fi_sequencer
    import pe_fi_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [1:0]       target,
    input  logic [1:0]       mode,
    input  logic [ACC_W-1:0] mask,
    input  logic [CNT_W-1:0] start,
    input  logic [CNT_W-1:0] len,
    input  logic             arm,
    output logic [1:0]       cfg_target,
    output logic [1:0]       cfg_mode,
    output logic [ACC_W-1:0] cfg_mask,
    output logic             fi_active,
    output logic             fi_done
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fi_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cfg_start;
    logic [CNT_W-1:0] cfg_len;

    // Configuration may only change while no window is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_target <= '0;
            cfg_mode   <= '0;
            cfg_mask   <= '0;
            cfg_start  <= '0;
            cfg_len    <= '0;
        end else if (cfg_we && (state == ST_IDLE || state == ST_DONE)) begin
            cfg_target <= target;
            cfg_mode   <= mode;
            cfg_mask   <= mask;
            cfg_start  <= start;
            cfg_len    <= len;
        end
    end

    // Arm from any state restarts the window; a zero length never leaves ACTIVE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else if (arm) begin
            state <= ST_ARMED;
            cnt   <= '0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (cnt == cfg_start) begin
                        state <= ST_ACTIVE;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (cfg_len != '0) begin
                        if (cnt == cfg_len) begin
                            state <= ST_DONE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign fi_active = (state == ST_ACTIVE) && (cfg_mode != MODE_NONE) && (cfg_target != TGT_NONE);
    assign fi_done   = (state == ST_DONE);

endmodule

// File: rtl/pe_ws_fi_dbuf.sv
// Weight-stationary systolic PE with double-buffered stationary operand and a
// port-programmable fault injector. Define PE_FI_STATS_EN to build the fi_hits counter.
module pe_ws_fi_dbuf
    import pe_fi_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int ACC_W = 2*D_W,
    parameter int CNT_W = 16,
    parameter int ROW   = 0,
    parameter int COL   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_load,
    input  logic             w_swap,
    input  logic [D_W-1:0]   in_stat,
    input  logic             in_valid,
    input  logic [D_W-1:0]   in_stream,
    input  logic [ACC_W-1:0] in_sum,
    output logic             out_valid,
    output logic [D_W-1:0]   out_stream,
    output logic [ACC_W-1:0] out_sum,
    input  logic             fi_cfg_we,
    input  logic [1:0]       fi_target,
    input  logic [1:0]       fi_mode,
    input  logic [ACC_W-1:0] fi_mask,
    input  logic [CNT_W-1:0] fi_start,
    input  logic [CNT_W-1:0] fi_len,
    input  logic             fi_arm,
    output logic             fi_active,
    output logic             fi_done,
    output logic [CNT_W-1:0] fi_hits
);

    if (ACC_W < 2*D_W || ACC_W > FI_MAX_W) begin : g_width_check
        $error("pe_ws_fi_dbuf: ACC_W must lie between 2*D_W and FI_MAX_W");
    end

    logic [1:0]              cfg_target;
    logic [1:0]              cfg_mode;
    logic [ACC_W-1:0]        cfg_mask;
    logic [D_W-1:0]          active;
    logic [D_W-1:0]          shadow;
    logic                    shadow_vld;
    logic [D_W-1:0]          stat_x;
    logic [D_W-1:0]          stream_x;
    logic [ACC_W-1:0]        sum_x;
    logic [D_W-1:0]          stat_f;
    logic [D_W-1:0]          stream_f;
    logic signed [2*D_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0]        sum_clean;
    logic [ACC_W-1:0]        sum_f;

    pe_fi_sequencer #(
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (fi_cfg_we),
        .target     (fi_target),
        .mode       (fi_mode),
        .mask       (fi_mask),
        .start      (fi_start),
        .len        (fi_len),
        .arm        (fi_arm),
        .cfg_target (cfg_target),
        .cfg_mode   (cfg_mode),
        .cfg_mask   (cfg_mask),
        .fi_active  (fi_active),
        .fi_done    (fi_done)
    );

    // Faulted candidates; the stored stationary value itself is never corrupted.
    assign stat_x   = D_W'(apply_fault(FI_MAX_W'(active), FI_MAX_W'(cfg_mask), fi_mode_e'(cfg_mode)));
    assign stream_x = D_W'(apply_fault(FI_MAX_W'(in_stream), FI_MAX_W'(cfg_mask), fi_mode_e'(cfg_mode)));
    assign sum_x    = ACC_W'(apply_fault(FI_MAX_W'(sum_clean), FI_MAX_W'(cfg_mask), fi_mode_e'(cfg_mode)));

    assign stat_f   = (fi_active && cfg_target == TGT_STAT)   ? stat_x   : active;
    assign stream_f = (fi_active && cfg_target == TGT_STREAM) ? stream_x : in_stream;

    assign prod      = (2*D_W)'($signed(stream_f)) * (2*D_W)'($signed(stat_f));
    assign prod_ext  = ACC_W'(prod);
    assign sum_clean = in_sum + prod_ext;
    assign sum_f     = (fi_active && cfg_target == TGT_PSUM) ? sum_x : sum_clean;

    // A simultaneous load and swap promotes the old shadow and keeps the new one pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active     <= '0;
            shadow     <= '0;
            shadow_vld <= 1'b0;
        end else begin
            if (w_swap && shadow_vld) begin
                active <= shadow;
            end
            if (w_load) begin
                shadow     <= in_stat;
                shadow_vld <= 1'b1;
            end else if (w_swap && shadow_vld) begin
                shadow_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_stream <= '0;
            out_sum    <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_stream <= stream_f;
                out_sum    <= sum_f;
            end
        end
    end

`ifdef PE_FI_STATS_EN
    logic             hit;
    logic [CNT_W-1:0] hits;

    assign hit = in_valid && fi_active &&
                 ((cfg_target == TGT_STAT   && stat_f   != active)    ||
                  (cfg_target == TGT_STREAM && stream_f != in_stream) ||
                  (cfg_target == TGT_PSUM   && sum_f    != sum_clean));

    // Saturating count of beats the fault actually changed; cleared by re-arm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits <= '0;
        end else if (fi_arm) begin
            hits <= '0;
        end else if (hit && hits != '1) begin
            hits <= hits + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign fi_hits = hits;
`else
    assign fi_hits = '0;
`endif

endmodule

// File: tb/tb_pe_ws_fi_dbuf.sv
// Self-checking bench for pe_ws_fi_dbuf: directed scenarios then random traffic,
// all compared against a cycle-level behavioural model.
module tb_pe_ws_fi_dbuf;

    localparam int D_W   = 8;
    localparam int ACC_W = 16;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             w_load;
    logic             w_swap;
    logic [D_W-1:0]   in_stat;
    logic             in_valid;
    logic [D_W-1:0]   in_stream;
    logic [ACC_W-1:0] in_sum;
    logic             out_valid;
    logic [D_W-1:0]   out_stream;
    logic [ACC_W-1:0] out_sum;
    logic             fi_cfg_we;
    logic [1:0]       fi_target;
    logic [1:0]       fi_mode;
    logic [ACC_W-1:0] fi_mask;
    logic [CNT_W-1:0] fi_start;
    logic [CNT_W-1:0] fi_len;
    logic             fi_arm;
    logic             fi_active;
    logic             fi_done;
    logic [CNT_W-1:0] fi_hits;

    pe_ws_fi_dbuf #(
        .D_W   (D_W),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W),
        .ROW   (0),
        .COL   (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .w_load     (w_load),
        .w_swap     (w_swap),
        .in_stat    (in_stat),
        .in_valid   (in_valid),
        .in_stream  (in_stream),
        .in_sum     (in_sum),
        .out_valid  (out_valid),
        .out_stream (out_stream),
        .out_sum    (out_sum),
        .fi_cfg_we  (fi_cfg_we),
        .fi_target  (fi_target),
        .fi_mode    (fi_mode),
        .fi_mask    (fi_mask),
        .fi_start   (fi_start),
        .fi_len     (fi_len),
        .fi_arm     (fi_arm),
        .fi_active  (fi_active),
        .fi_done    (fi_done),
        .fi_hits    (fi_hits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: operand registers plus "cycles since arm" for the window.
    logic [7:0]  m_active, m_shadow, m_stream;
    logic [15:0] m_sum;
    bit          m_svld, m_valid, m_armed;
    int          m_k, m_hits;
    logic [1:0]  c_target, c_mode, r_target, r_mode;
    logic [15:0] c_mask, r_mask;
    int          c_start, c_len, r_start, r_len;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] faultVal(input logic [15:0] v, input logic [15:0] m, input logic [1:0] mode);
        case (mode)
            2'd1:    return v ^ m;
            2'd2:    return v & ~m;
            2'd3:    return v | m;
            default: return v;
        endcase
    endfunction

    function automatic bit modelActive();
        return m_armed && (m_k >= r_start + 1) && (r_len == 0 || m_k <= r_start + r_len)
               && r_mode != 2'd0 && r_target != 2'd3;
    endfunction

    function automatic bit modelDone();
        return m_armed && r_len != 0 && (m_k >= r_start + r_len + 1);
    endfunction

    task automatic modelReset();
        m_active = 0; m_shadow = 0; m_stream = 0; m_sum = 0;
        m_svld = 0; m_valid = 0; m_armed = 0; m_k = 0; m_hits = 0;
        c_target = 0; c_mode = 0; c_mask = 0; c_start = 0; c_len = 0;
        r_target = 0; r_mode = 0; r_mask = 0; r_start = 0; r_len = 0;
    endtask

    task automatic clearInputs();
        w_load = 0; w_swap = 0; in_stat = 0; in_valid = 0; in_stream = 0; in_sum = 0;
        fi_cfg_we = 0; fi_target = 0; fi_mode = 0; fi_mask = 0; fi_start = 0; fi_len = 0; fi_arm = 0;
    endtask

    // One clock with the currently driven inputs; model advances, then all outputs are compared.
    task automatic applyStimulus();
        bit          fa, hit, done_now;
        logic [15:0] t, sum_c, sum_f;
        logic [7:0]  st_f, sm_f;
        int          prod;
        fa       = modelActive();
        done_now = modelDone();
        st_f = m_active;
        sm_f = in_stream;
        if (fa && r_target == 2'd0) begin t = faultVal({8'h00, m_active}, r_mask, r_mode); st_f = t[7:0]; end
        if (fa && r_target == 2'd1) begin t = faultVal({8'h00, in_stream}, r_mask, r_mode); sm_f = t[7:0]; end
        prod  = int'($signed(st_f)) * int'($signed(sm_f));
        sum_c = in_sum + prod[15:0];
        sum_f = (fa && r_target == 2'd2) ? faultVal(sum_c, r_mask, r_mode) : sum_c;
        hit = in_valid && fa && ((r_target == 2'd0 && st_f != m_active) ||
                                 (r_target == 2'd1 && sm_f != in_stream) ||
                                 (r_target == 2'd2 && sum_f != sum_c));
        m_valid = in_valid;
        if (in_valid) begin m_sum = sum_f; m_stream = sm_f; end
        if (w_swap && m_svld) begin m_active = m_shadow; m_svld = 0; end
        if (w_load) begin m_shadow = in_stat; m_svld = 1; end
        if (fi_arm) m_hits = 0;
        else if (hit && m_hits < 65535) m_hits++;
        if (fi_cfg_we && (!m_armed || done_now)) begin
            c_target = fi_target; c_mode = fi_mode; c_mask = fi_mask;
            c_start = int'(fi_start); c_len = int'(fi_len);
        end
        if (fi_arm) begin
            m_armed = 1; m_k = 0;
            r_target = c_target; r_mode = c_mode; r_mask = c_mask; r_start = c_start; r_len = c_len;
        end else if (m_armed && m_k < 1000000) begin
            m_k++;
        end
        @(posedge clk);
        #1;
        checkOutput("out_valid", out_valid, m_valid);
        checkOutput("out_stream", out_stream, m_stream);
        checkOutput("out_sum", out_sum, m_sum);
        checkOutput("fi_active", fi_active, modelActive());
        checkOutput("fi_done", fi_done, modelDone());
`ifdef PE_FI_STATS_EN
        checkOutput("fi_hits", fi_hits, m_hits);
`else
        checkOutput("fi_hits", fi_hits, 0);
`endif
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic doReset(input string tag);
        #2 rst = 1'b1;
        #1;
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_stream"}, out_stream, 0);
        checkOutput({tag, "_sum"}, out_sum, 0);
        checkOutput({tag, "_active"}, fi_active, 0);
        checkOutput({tag, "_done"}, fi_done, 0);
        checkOutput({tag, "_hits"}, fi_hits, 0);
        modelReset();
        clearInputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setCfg(input logic [1:0] tg, input logic [1:0] md, input logic [15:0] mk,
                          input logic [15:0] st, input logic [15:0] ln);
        clearInputs();
        fi_cfg_we = 1; fi_target = tg; fi_mode = md; fi_mask = mk; fi_start = st; fi_len = ln;
        applyStimulus();
    endtask

    task automatic beat(input logic [7:0] s, input logic [15:0] p);
        clearInputs();
        in_valid = 1; in_stream = s; in_sum = p;
        applyStimulus();
    endtask

    task automatic armOnce();
        clearInputs();
        fi_arm = 1;
        applyStimulus();
    endtask

    task automatic loadSwap(input logic [7:0] v);
        clearInputs(); w_load = 1; in_stat = v; applyStimulus();
        clearInputs(); w_swap = 1; applyStimulus();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        clearInputs();
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("init_valid", out_valid, 0);
        checkOutput("init_sum", out_sum, 0);
        checkOutput("init_active", fi_active, 0);
        checkOutput("init_done", fi_done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Plain MAC
        loadSwap(8'd3);
        beat(8'd5, 16'd10);
        checkOutput("t1_sum", out_sum, 16'd25);
        checkOutput("t1_stream", out_stream, 8'd5);

        // One-cycle stationary bit-flip window
        setCfg(2'd0, 2'd1, 16'h0001, 16'd0, 16'd1);
        armOnce();
        beat(8'd5, 16'd10);
        checkOutput("t2_pre", out_sum, 16'd25);
        checkOutput("t2_act", fi_active, 1);
        beat(8'd5, 16'd10);
        checkOutput("t2_win", out_sum, 16'd20);
        checkOutput("t2_done", fi_done, 1);
        beat(8'd5, 16'd10);
        checkOutput("t2_after", out_sum, 16'd25);

        // Permanent stuck-at-1 on the stream
        setCfg(2'd1, 2'd3, 16'h0080, 16'd0, 16'd0);
        armOnce();
        beat(8'd5, 16'd10);
        for (int i = 0; i < 3; i++) begin
            beat(8'd5, 16'd10);
            checkOutput("t3_stream", out_stream, 8'h85);
            checkOutput("t3_sum", out_sum, 16'hFE99);
            checkOutput("t3_done", fi_done, 0);
        end

        // Wraparound, then psum stuck-at-0
        doReset("t4_rst");
        loadSwap(8'd1);
        beat(8'd1, 16'h7FFF);
        checkOutput("t4_wrap", out_sum, 16'h8000);
        setCfg(2'd2, 2'd2, 16'hFFFF, 16'd0, 16'd0);
        armOnce();
        beat(8'd1, 16'h7FFF);
        beat(8'd1, 16'h7FFF);
        checkOutput("t4_sa0", out_sum, 16'h0000);

        // Window timing, then reset inside the window
        doReset("t5_rst0");
        loadSwap(8'd2);
        setCfg(2'd1, 2'd1, 16'h0001, 16'd4, 16'd3);
        armOnce();
        for (int i = 1; i <= 9; i++) begin
            beat(8'($urandom), 16'($urandom));
            checkOutput("t5_active", fi_active, (i >= 5 && i <= 7));
            checkOutput("t5_done", fi_done, (i >= 8));
        end
        armOnce();
        for (int i = 1; i <= 6; i++) beat(8'($urandom), 16'($urandom));
        checkOutput("t5_mid", fi_active, 1);
        doReset("t5_rst");

        // Double buffer corner cases
        clearInputs(); w_load = 1; in_stat = 8'd3; applyStimulus();
        clearInputs(); w_load = 1; in_stat = 8'd7; w_swap = 1; applyStimulus();
        beat(8'd1, 16'd0);
        checkOutput("t6_both", out_sum, 16'd3);
        clearInputs(); w_swap = 1; applyStimulus();
        beat(8'd1, 16'd0);
        checkOutput("t6_swap", out_sum, 16'd7);
        clearInputs(); w_swap = 1; applyStimulus();
        beat(8'd1, 16'd0);
        checkOutput("t6_noswap", out_sum, 16'd7);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                doReset("rnd_rst");
            end else begin
                clearInputs();
                w_load    = ($urandom_range(0, 7) == 0);
                w_swap    = ($urandom_range(0, 7) == 0);
                in_stat   = 8'($urandom);
                in_valid  = ($urandom_range(0, 3) != 0);
                in_stream = 8'($urandom);
                in_sum    = 16'($urandom);
                fi_cfg_we = ($urandom_range(0, 19) == 0);
                fi_target = 2'($urandom_range(0, 3));
                fi_mode   = 2'($urandom_range(0, 3));
                fi_mask   = 16'($urandom);
                fi_start  = 16'($urandom_range(0, 6));
                fi_len    = 16'($urandom_range(0, 5));
                fi_arm    = ($urandom_range(0, 29) == 0);
                applyStimulus();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
